// File: rtl/memory_pkg.sv
// Shared types for the RV32I data memory controller: access-size and
// error-code encodings plus the controller state type.
package memory_pkg;

    localparam int MEM_WORD_WIDTH  = 32;
    localparam int MEM_ADDR_WIDTH  = 32;
    localparam int ERR_ENUMS_WIDTH = 2;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_RSVD = 2'b11
    } e_mem_size;

    typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE,
        ERR_SIZE
    } e_mem_err;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } e_mem_ctrl_state;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store stage (master) and the
// data memory controller (slave).
interface data_mem_ctrl_if
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int WORD_WIDTH = MEM_WORD_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    e_mem_size             req_size;
    logic                  req_unsigned;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    e_mem_err              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_array.sv
// Plain byte-lane storage: four independent byte lanes sharing one word
// index, per-lane write enables, asynchronous 4-byte read. Not reset.
module mem_byte_array #(
    parameter int DEPTH_WORDS = 16384,
    parameter int IDX_WIDTH   = 14
) (
    input  logic                 clk,
    input  logic [IDX_WIDTH-1:0] addr,
    input  logic [3:0]           wr_en,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] bytes [DEPTH_WORDS];

        // Write this lane's byte when its enable is set
        always_ff @(posedge clk) begin
            if (wr_en[lane]) begin
                bytes[addr] <= wdata[8*lane +: 8];
            end
        end

        assign rdata[8*lane +: 8] = bytes[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory controller with a
// request/response handshake, size/alignment/range checking and
// sign/zero extension of sub-word loads. One transaction in flight.
// Optional error status outputs: define DATA_MEM_ERR_STATUS_EN.
module data_mem_ctrl #(
    parameter int MEM_WORD_WIDTH  = 32,
    parameter int MEM_ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH_BYTES = 65536,
    parameter int RD_LATENCY      = 1
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef DATA_MEM_ERR_STATUS_EN
    output logic [1:0]  err_sticky,
    output logic [15:0] err_count,
`endif
    data_mem_ctrl_if.slave bus
);

    import memory_pkg::*;

    localparam int IDX_WIDTH   = $clog2(MEM_DEPTH_BYTES);
    localparam int DEPTH_WORDS = MEM_DEPTH_BYTES / 4;
    localparam int WIDX_WIDTH  = (IDX_WIDTH > 2) ? IDX_WIDTH - 2 : 1;
    localparam int CNT_WIDTH   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [MEM_ADDR_WIDTH:0] DEPTH_LIMIT = (MEM_ADDR_WIDTH+1)'(MEM_DEPTH_BYTES);

    e_mem_ctrl_state             state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        accept;
    logic                        in_range;
    logic [IDX_WIDTH-1:0]        byte_idx;
    logic [1:0]                  lane_off;
    logic [WIDX_WIDTH-1:0]       word_idx;
    e_mem_err                    err_chk;
    logic [3:0]                  wr_lanes;
    logic [3:0]                  mem_wr_en;
    logic [MEM_WORD_WIDTH-1:0]   wr_data;
    logic [MEM_WORD_WIDTH-1:0]   rd_word;
    logic [MEM_WORD_WIDTH-1:0]   rd_shift;
    logic [MEM_WORD_WIDTH-1:0]   load_result;
    logic [MEM_WORD_WIDTH-1:0]   rdata_q;
    e_mem_err                    err_q;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign in_range = ({1'b0, bus.req_addr} < DEPTH_LIMIT);
    assign byte_idx = bus.req_addr[IDX_WIDTH-1:0];
    assign lane_off = byte_idx[1:0];
    assign word_idx = WIDX_WIDTH'(byte_idx >> 2);

    // Error classification of the presented request, highest priority first
    always_comb begin
        err_chk = ERR_NONE;
        if (bus.req_size == SIZE_RSVD) begin
            err_chk = ERR_SIZE;
        end else if ((bus.req_size == SIZE_WORD && lane_off != 2'b00) ||
                     (bus.req_size == SIZE_HALF && lane_off[0])) begin
            err_chk = ERR_MISALIGN;
        end else if (!in_range) begin
            err_chk = ERR_RANGE;
        end
    end

    // Steer right-aligned store data onto the byte lanes selected by the address
    always_comb begin
        wr_lanes = '0;
        wr_data  = bus.req_wdata;
        case (bus.req_size)
            SIZE_BYTE: begin
                wr_lanes = 4'b0001 << lane_off;
                wr_data  = {4{bus.req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                wr_lanes = 4'b0011 << lane_off;
                wr_data  = {2{bus.req_wdata[15:0]}};
            end
            SIZE_WORD: wr_lanes = 4'b1111;
            default:   wr_lanes = '0;
        endcase
    end

    // Stores commit on the acceptance edge; errored requests never write
    assign mem_wr_en = (accept && bus.req_we && err_chk == ERR_NONE) ? wr_lanes : '0;

    mem_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_WIDTH   (WIDX_WIDTH)
    ) u_array (
        .clk   (clk),
        .addr  (word_idx),
        .wr_en (mem_wr_en),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    assign rd_shift = rd_word >> {lane_off, 3'b000};

    // Extract the addressed bytes and extend; stores and errors return zero
    always_comb begin
        load_result = '0;
        case (bus.req_size)
            SIZE_BYTE: load_result = bus.req_unsigned ? {24'd0, rd_shift[7:0]}
                                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SIZE_HALF: load_result = bus.req_unsigned ? {16'd0, rd_shift[15:0]}
                                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            SIZE_WORD: load_result = rd_word;
            default:   load_result = '0;
        endcase
        if (bus.req_we || err_chk != ERR_NONE) begin
            load_result = '0;
        end
    end

    // Capture the response payload at acceptance and hold it until the next request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else if (accept) begin
            rdata_q <= load_result;
            err_q   <= err_chk;
        end
    end

    // State and latency counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE accepts, WAIT counts latency down, RESP waits for the consumer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_WIDTH'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

`ifdef DATA_MEM_ERR_STATUS_EN
    e_mem_err    sticky_q;
    logic [15:0] count_q;

    // Remember the first error code and count errored requests, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= ERR_NONE;
            count_q  <= '0;
        end else if (accept && err_chk != ERR_NONE) begin
            if (sticky_q == ERR_NONE) begin
                sticky_q <= err_chk;
            end
            if (count_q != '1) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign err_sticky = sticky_q;
    assign err_count  = count_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a latency-1 instance driven by a
// directed vector table and a latency-3, 256-byte instance driven by
// corner-case sequences and random traffic against a byte-array model.
module tb_data_mem_ctrl;
    import memory_pkg::*;

    localparam int DEPTH3 = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn1;
    logic rstn3;
    int   n_cmp = 0;
    int   n_bad = 0;

    data_mem_ctrl_if bus1 ();
    data_mem_ctrl_if bus3 ();

`ifdef DATA_MEM_ERR_STATUS_EN
    logic [1:0]  sticky1, sticky3;
    logic [15:0] count1, count3;
`endif

    data_mem_ctrl #(
        .MEM_WORD_WIDTH  (32),
        .MEM_ADDR_WIDTH  (32),
        .MEM_DEPTH_BYTES (65536),
        .RD_LATENCY      (1)
    ) dut1 (
        .clk        (clk),
        .rstn       (rstn1),
`ifdef DATA_MEM_ERR_STATUS_EN
        .err_sticky (sticky1),
        .err_count  (count1),
`endif
        .bus        (bus1)
    );

    data_mem_ctrl #(
        .MEM_WORD_WIDTH  (32),
        .MEM_ADDR_WIDTH  (32),
        .MEM_DEPTH_BYTES (DEPTH3),
        .RD_LATENCY      (3)
    ) dut3 (
        .clk        (clk),
        .rstn       (rstn3),
`ifdef DATA_MEM_ERR_STATUS_EN
        .err_sticky (sticky3),
        .err_count  (count3),
`endif
        .bus        (bus3)
    );

    // Reference storage for the 256-byte instance
    logic [7:0] mem3 [DEPTH3];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int d, input logic v, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wd);
        if (d == 1) begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
            bus1.req_size = e_mem_size'(size); bus1.req_unsigned = uns; bus1.req_wdata = wd;
        end else begin
            bus3.req_valid = v; bus3.req_we = we; bus3.req_addr = addr;
            bus3.req_size = e_mem_size'(size); bus3.req_unsigned = uns; bus3.req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input int d, input logic v);
        if (d == 1) bus1.rsp_ready = v;
        else        bus3.rsp_ready = v;
    endtask

    function automatic logic get_rv(input int d);
        return (d == 1) ? bus1.rsp_valid : bus3.rsp_valid;
    endfunction

    function automatic logic get_rr(input int d);
        return (d == 1) ? bus1.req_ready : bus3.req_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 1) ? bus1.rsp_rdata : bus3.rsp_rdata;
    endfunction

    function automatic logic [1:0] get_err(input int d);
        return (d == 1) ? bus1.rsp_err : bus3.rsp_err;
    endfunction

    // Behavioural model: byte-addressed array, alignment by modulo, extension by arithmetic
    function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                       input logic uns, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic [1:0] er);
        longint unsigned a;
        int              n;
        longint          val;
        a  = addr;
        n  = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        rd = '0;
        if (size == 2'd3)                 er = 2'd3;
        else if (a % n != 0)              er = 2'd1;
        else if (a >= longint'(DEPTH3))   er = 2'd2;
        else                              er = 2'd0;
        if (er == 2'd0) begin
            if (we) begin
                for (int i = 0; i < n; i++) mem3[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val += longint'(mem3[int'(a) + i]) << (8 * i);
                if (!uns && n < 4 && val >= (64'sd1 <<< (8 * n - 1))) val -= (64'sd1 <<< (8 * n));
                rd = val[31:0];
            end
        end
    endfunction

    // One full transaction; starts and ends just after a falling edge.
    // hold < 0 keeps rsp_ready high from the start, otherwise rsp_ready is held low for hold cycles.
    task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input int hold, input string tag,
                       output logic [31:0] rd, output logic [1:0] er, output int lat);
        bit ready_leak;
        bit unstable;
        drive_req(d, 1'b1, we, addr, size, uns, wd);
        if (hold < 0) set_rsp_ready(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_req(d, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        lat = 1;
        ready_leak = 1'b0;
        while (!get_rv(d) && lat < 40) begin
            if (get_rr(d)) ready_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp_valid"}, 32'(get_rv(d)), 32'd1);
        rd = get_rdata(d);
        er = get_err(d);
        if (!get_rv(d)) begin
            set_rsp_ready(d, 1'b0);
            return;
        end
        if (lat > 1) check({tag, "_busy_ready"}, 32'(ready_leak), 32'd0);
        check({tag, "_resp_ready"}, 32'(get_rr(d)), 32'd0);
        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!get_rv(d) || get_rdata(d) !== rd || get_err(d) !== er || get_rr(d)) unstable = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
        set_rsp_ready(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rsp_ready(d, 1'b0);
        check({tag, "_post_hs"}, 32'({get_rr(d), get_rv(d)}), 32'b10);
    endtask

    function automatic void add_vec(input string name, input logic we, input logic [31:0] addr,
                                    input logic [1:0] size, input logic uns, input logic [31:0] wd,
                                    input logic [31:0] exp_rd, input logic [1:0] exp_er);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wd; v.exp_rdata = exp_rd; v.exp_err = exp_er;
        vecs.push_back(v);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd, exp_rd, addr, wd;
        logic [1:0]  er, exp_er, size;
        logic        we, uns;
        int          lat, hold, n_err_vec, seen;
        logic [1:0]  first_err;

        rstn1 = 1'b0;
        rstn3 = 1'b0;
        drive_req(1, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        drive_req(3, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        set_rsp_ready(1, 1'b0);
        set_rsp_ready(3, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Values while reset is asserted
        check("rst1_req_ready", 32'(bus1.req_ready), 32'd1);
        check("rst1_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst1_rsp_rdata", bus1.rsp_rdata, 32'd0);
        check("rst1_rsp_err",   32'(bus1.rsp_err), 32'd0);
        check("rst3_req_ready", 32'(bus3.req_ready), 32'd1);
        check("rst3_rsp_valid", 32'(bus3.rsp_valid), 32'd0);
`ifdef DATA_MEM_ERR_STATUS_EN
        check("rst1_err_sticky", 32'(sticky1), 32'd0);
        check("rst1_err_count",  32'(count1), 32'd0);
`endif
        rstn1 = 1'b1;
        rstn3 = 1'b1;
        @(negedge clk);

        // Directed table on the latency-1, 64 KiB instance
        add_vec("st_w0",        1'b1, 32'h0000_0000, 2'd0, 1'b0, 32'h1234_5678, 32'h0,          2'd0);
        add_vec("st_w10",       1'b1, 32'h0000_0010, 2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0,          2'd0);
        add_vec("ld_w10",       1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0,         32'hDEAD_BEEF,  2'd0);
        add_vec("ld_b13_s",     1'b0, 32'h0000_0013, 2'd2, 1'b0, 32'h0,         32'hFFFF_FFDE,  2'd0);
        add_vec("ld_b13_u",     1'b0, 32'h0000_0013, 2'd2, 1'b1, 32'h0,         32'h0000_00DE,  2'd0);
        add_vec("ld_h12_s",     1'b0, 32'h0000_0012, 2'd1, 1'b0, 32'h0,         32'hFFFF_DEAD,  2'd0);
        add_vec("ld_h10_u",     1'b0, 32'h0000_0010, 2'd1, 1'b1, 32'h0,         32'h0000_BEEF,  2'd0);
        add_vec("ld_b10_s",     1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,         32'hFFFF_FFEF,  2'd0);
        add_vec("ld_w02_mis",   1'b0, 32'h0000_0002, 2'd0, 1'b0, 32'h0,         32'h0,          2'd1);
        add_vec("st_b_range",   1'b1, 32'h0001_0000, 2'd2, 1'b0, 32'h0000_0055, 32'h0,          2'd2);
        add_vec("ld_w0_keep",   1'b0, 32'h0000_0000, 2'd0, 1'b0, 32'h0,         32'h1234_5678,  2'd0);
        add_vec("rsvd_03",      1'b0, 32'h0000_0003, 2'd3, 1'b0, 32'h0,         32'h0,          2'd3);
        add_vec("st_h12",       1'b1, 32'h0000_0012, 2'd1, 1'b0, 32'hFFFF_CAFE, 32'h0,          2'd0);
        add_vec("ld_w10_h",     1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0,         32'hCAFE_BEEF,  2'd0);
        add_vec("st_b11",       1'b1, 32'h0000_0011, 2'd2, 1'b0, 32'hAAAA_AA7F, 32'h0,          2'd0);
        add_vec("ld_w10_b",     1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0,         32'hCAFE_7FEF,  2'd0);
        add_vec("ld_h11_mis",   1'b0, 32'h0000_0011, 2'd1, 1'b1, 32'h0,         32'h0,          2'd1);
        add_vec("st_w12_mis",   1'b1, 32'h0000_0012, 2'd0, 1'b0, 32'h1111_1111, 32'h0,          2'd1);
        add_vec("ld_w10_keep",  1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0,         32'hCAFE_7FEF,  2'd0);
        add_vec("st_w_top",     1'b1, 32'h0000_FFFC, 2'd0, 1'b0, 32'hA5A5_0001, 32'h0,          2'd0);
        add_vec("ld_w_top_u",   1'b0, 32'h0000_FFFC, 2'd0, 1'b1, 32'h0,         32'hA5A5_0001,  2'd0);
        add_vec("ld_bffff_s",   1'b0, 32'h0000_FFFF, 2'd2, 1'b0, 32'h0,         32'hFFFF_FFA5,  2'd0);
        add_vec("ld_hfffe_u",   1'b0, 32'h0000_FFFE, 2'd1, 1'b1, 32'h0,         32'h0000_A5A5,  2'd0);
        add_vec("ld_b_hi_rng",  1'b0, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'h0,         32'h0,          2'd2);
        add_vec("ld_w_alias",   1'b0, 32'h0001_0010, 2'd0, 1'b0, 32'h0,         32'h0,          2'd2);

        n_err_vec = 0;
        first_err = 2'd0;
        foreach (vecs[i]) begin
            txn(1, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                i % 3, vecs[i].name, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            if (vecs[i].exp_err != 2'd0) begin
                n_err_vec++;
                if (first_err == 2'd0) first_err = vecs[i].exp_err;
            end
        end
`ifdef DATA_MEM_ERR_STATUS_EN
        check("err_sticky", 32'(sticky1), 32'(first_err));
        check("err_count",  32'(count1), 32'(n_err_vec));
`endif

        // Latency-3 instance: initialise every word through the bus
        for (int i = 0; i < DEPTH3 / 4; i++) begin
            wd = $urandom;
            ref_access(1'b1, 32'(i * 4), 2'd0, 1'b0, wd, exp_rd, exp_er);
            txn(3, 1'b1, 32'(i * 4), 2'd0, 1'b0, wd, 0, "fill", rd, er, lat);
            check("fill_err", 32'(er), 32'(exp_er));
            check("fill_lat", 32'(lat), 32'd3);
        end

        // Consumer stalls for 5 cycles: payload must stay put
        ref_access(1'b0, 32'h8, 2'd0, 1'b0, '0, exp_rd, exp_er);
        txn(3, 1'b0, 32'h8, 2'd0, 1'b0, '0, 5, "stall5", rd, er, lat);
        check("stall5_rdata", rd, exp_rd);
        check("stall5_lat", 32'(lat), 32'd3);

        // Reset while waiting after a byte store: store stays committed
        drive_req(3, 1'b1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h0000_00AA);
        @(posedge clk);
        @(negedge clk);
        drive_req(3, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        check("wait_state", 32'({bus3.req_ready, bus3.rsp_valid}), 32'b00);
        #2 rstn3 = 1'b0;
        #1;
        check("rst_in_wait", 32'({bus3.req_ready, bus3.rsp_valid}), 32'b10);
        @(negedge clk);
        rstn3 = 1'b1;
        ref_access(1'b1, 32'h20, 2'd2, 1'b0, 32'h0000_00AA, exp_rd, exp_er);
        @(negedge clk);
        txn(3, 1'b0, 32'h20, 2'd2, 1'b0, '0, 1, "post_rst_ld", rd, er, lat);
        check("post_rst_ld_rdata", rd, 32'hFFFF_FFAA);
        check("post_rst_ld_err", 32'(er), 32'd0);

        // Reset while a response is presented: it must vanish at once
        drive_req(3, 1'b1, 1'b0, 32'h20, 2'd0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        drive_req(3, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        seen = 0;
        while (!bus3.rsp_valid && seen < 10) begin
            @(negedge clk);
            seen++;
        end
        check("resp_before_rst", 32'(bus3.rsp_valid), 32'd1);
        #2 rstn3 = 1'b0;
        #1;
        check("rst_in_resp", 32'({bus3.req_ready, bus3.rsp_valid, bus3.rsp_err}), 32'b1000);
        check("rst_in_resp_rdata", bus3.rsp_rdata, 32'd0);
        @(negedge clk);
        rstn3 = 1'b1;
        @(negedge clk);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            we   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 99) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                addr = $urandom | 32'(DEPTH3);
            end else begin
                addr = 32'($urandom_range(0, DEPTH3 - 1));
                if ($urandom_range(0, 9) < 7) begin
                    if (size == 2'd0) addr = addr & ~32'h3;
                    if (size == 2'd1) addr = addr & ~32'h1;
                end
            end
            hold = int'($urandom_range(0, 3)) - 1;
            ref_access(we, addr, size, uns, wd, exp_rd, exp_er);
            txn(3, we, addr, size, uns, wd, hold, "rand", rd, er, lat);
            check("rand_rdata", rd, exp_rd);
            check("rand_err", 32'(er), 32'(exp_er));
            check("rand_lat", 32'(lat), 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
